// File: rtl/case_4_mul_share_ctrl_pkg.sv
// Shared constants, pipeline stage record and arithmetic helpers for the
// shared signed multiplier controller.
package case_4_mul_pkg;

  localparam int NUM_REQ = 4;
  localparam int DIN0_W  = 13;
  localparam int DIN1_W  = 8;
  localparam int DOUT_W  = 13;
  localparam int LAT     = 2;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int PROD_W  = DIN0_W + DIN1_W;

  typedef struct packed {
    logic              vld;
    logic [ID_W-1:0]   id;
    logic [DOUT_W-1:0] data;
  } stage_t;

  // Full-width signed product, wrapped to the low DOUT_W bits.
  function automatic logic [DOUT_W-1:0] mul_trunc(input logic [DIN0_W-1:0] a,
                                                  input logic [DIN1_W-1:0] b);
    return DOUT_W'(PROD_W'($signed(a)) * PROD_W'($signed(b)));
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
    if (p == ID_W'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return p + ID_W'(1);
    end
  endfunction

endpackage

// File: rtl/case_4_mul_share_ctrl_if.sv
// Request/response bundle between the requesters (master side) and the
// shared multiplier controller (slave side).
interface case_4_mul_share_ctrl_if;
  import case_4_mul_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DIN0_W-1:0] req_din0;
  logic [NUM_REQ*DIN1_W-1:0] req_din1;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DOUT_W-1:0]         rsp_dout;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  modport master (
    output req_valid, req_din0, req_din1, rsp_ready,
    input  req_ready, rsp_valid, rsp_dout, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_din0, req_din1, rsp_ready,
    output req_ready, rsp_valid, rsp_dout, rsp_id, busy
  );

endinterface

// File: rtl/case_4_mul_share_ctrl_arb.sv
// Combinational round-robin arbiter: scans upward from rr_ptr (modulo
// NUM_REQ) and grants the first valid requester when the pipe can advance.
module case_4_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      rr_ptr,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_vld
);

  localparam int SW = IW + 1;

  logic [SW-1:0] sum_s;
  logic [IW-1:0] cand_s;

  // Priority scan starting at rr_ptr; the wrap is done by a single subtract
  // so non-power-of-two requester counts work.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    grant     = '0;
    sum_s     = '0;
    cand_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, rr_ptr} + SW'(k);
      if (sum_s >= SW'(NUM_REQ)) begin
        sum_s = sum_s - SW'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IW-1:0];
      if (!grant_vld && req_valid[cand_s]) begin
        grant_vld = 1'b1;
        grant_idx = cand_s;
      end else begin
        grant_vld = grant_vld;
      end
    end
    if (grant_vld && adv) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/case_4_mul_share_ctrl.sv
// Shares one signed multiplier among NUM_REQ requesters: round-robin accept,
// LAT-deep stallable result pipe, tagged single response channel.
module case_4_mul_share_ctrl
  import case_4_mul_pkg::*;
(
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  case_4_mul_share_ctrl_if.slave  bus
);

  stage_t             pipe_r     [LAT];
  stage_t             pipe_nxt_s [LAT];
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    rr_nxt_s;
  logic               busy_r;
  logic               busy_nxt_s;
  logic               adv_s;
  logic               accept_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic               grant_vld_s;
  logic [DIN0_W-1:0]  din0_s;
  logic [DIN1_W-1:0]  din1_s;
  logic [DOUT_W-1:0]  prod_s;

  // A full output register only moves when downstream takes it.
  assign adv_s = ~pipe_r[LAT-1].vld | bus.rsp_ready;

  case_4_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_r),
    .adv       (adv_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  assign accept_s = grant_vld_s & adv_s & ~ap_rst;

  // Ready is suppressed for the whole reset cycle.
  always_comb begin
    ready_s = '0;
    if (ap_rst) begin
      ready_s = '0;
    end else begin
      ready_s = grant_s;
    end
  end

  assign din0_s = bus.req_din0[int'(grant_idx_s)*DIN0_W +: DIN0_W];
  assign din1_s = bus.req_din1[int'(grant_idx_s)*DIN1_W +: DIN1_W];
  assign prod_s = mul_trunc(din0_s, din1_s);

  // Next pipe contents: stage 0 takes the product or a bubble, later stages shift.
  always_comb begin
    for (int i = 0; i < LAT; i++) begin
      pipe_nxt_s[i] = pipe_r[i];
    end
    if (adv_s) begin
      if (accept_s) begin
        pipe_nxt_s[0].vld  = 1'b1;
        pipe_nxt_s[0].id   = grant_idx_s;
        pipe_nxt_s[0].data = prod_s;
      end else begin
        pipe_nxt_s[0] = '0;
      end
      for (int i = 1; i < LAT; i++) begin
        pipe_nxt_s[i] = pipe_r[i-1];
      end
    end else begin
      pipe_nxt_s[0] = pipe_r[0];
    end
  end

  // Pointer advance and busy look-ahead.
  always_comb begin
    busy_nxt_s = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      busy_nxt_s = busy_nxt_s | pipe_nxt_s[i].vld;
    end
    if (accept_s) begin
      rr_nxt_s = next_ptr(grant_idx_s);
    end else begin
      rr_nxt_s = rr_ptr_r;
    end
  end

  // State registers; reset drops in-flight ops without draining them.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_r[i] <= '0;
      end
      rr_ptr_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      pipe_r   <= pipe_nxt_s;
      rr_ptr_r <= rr_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = pipe_r[LAT-1].vld;
  assign bus.rsp_dout  = pipe_r[LAT-1].data;
  assign bus.rsp_id    = pipe_r[LAT-1].id;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_case_4_mul_share_ctrl.sv
// Bench for case_4_mul_share_ctrl: directed scenarios plus a random phase,
// checked cycle by cycle against a queue-based latency-line model.
module tb_case_4_mul_share_ctrl;
  import case_4_mul_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst;

  case_4_mul_share_ctrl_if bus();

  case_4_mul_share_ctrl dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct { bit v; int id; int dat; } slot_t;

  int n_chk = 0;
  int n_pass = 0;

  bit [NUM_REQ-1:0] vld;
  int d0 [NUM_REQ];
  int d1 [NUM_REQ];
  int quota [NUM_REQ];
  int mode;                 // 2: random raise/keep, otherwise quota-driven
  slot_t pipe_q [$];        // index 0 newest, index LAT-1 at the output
  int rr;
  int acc_cnt, rsp_cnt;
  int acc_log [$];
  int last_dout, last_id;
  bit saw_rsp;

  function automatic int trunc_mul(int a, int b);
    return (a * b) & ((1 << DOUT_W) - 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic new_data(int i);
    d0[i] = int'($urandom_range(0, 8191)) - 4096;
    d1[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic clear_model();
    slot_t b;
    b.v = 1'b0; b.id = 0; b.dat = 0;
    pipe_q = {};
    repeat (LAT) pipe_q.push_back(b);
    rr = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i] = vld[i];
      bus.req_din0[i*DIN0_W +: DIN0_W] = DIN0_W'(d0[i]);
      bus.req_din1[i*DIN1_W +: DIN1_W] = DIN1_W'(d1[i]);
    end
  endtask

  // One clock: check at negedge against the model, advance model at posedge.
  task automatic cycle();
    bit ev, adv, found, bz;
    int g, c;
    logic [NUM_REQ-1:0] er;
    slot_t s;
    drive();
    @(negedge ap_clk);
    ev  = pipe_q[LAT-1].v;
    adv = !ev || bus.rsp_ready;
    found = 1'b0; g = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (rr + k) % NUM_REQ;
      if (!found && vld[c]) begin found = 1'b1; g = c; end
    end
    er = '0;
    if (!ap_rst && adv && found) er[g] = 1'b1;
    bz = 1'b0;
    foreach (pipe_q[i]) if (pipe_q[i].v) bz = 1'b1;
    chk("req_ready", bus.req_ready, er);
    chk("rsp_valid", bus.rsp_valid, ev);
    chk("busy", bus.busy, bz);
    if (ev) begin
      chk("rsp_dout", bus.rsp_dout, pipe_q[LAT-1].dat);
      chk("rsp_id", bus.rsp_id, pipe_q[LAT-1].id);
    end
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
      rsp_cnt++;
      last_dout = int'(bus.rsp_dout);
      last_id   = int'(bus.rsp_id);
      saw_rsp   = 1'b1;
    end
    @(posedge ap_clk);
    if (ap_rst) begin
      clear_model();
    end else if (adv) begin
      s.v = found; s.id = found ? g : 0;
      s.dat = found ? trunc_mul(d0[g], d1[g]) : 0;
      void'(pipe_q.pop_back());
      pipe_q.push_front(s);
      if (found) begin
        rr = (g + 1) % NUM_REQ;
        acc_cnt++;
        acc_log.push_back(g);
        new_data(g);
        if (mode == 2) begin
          vld[g] = ($urandom_range(0, 1) == 1);
        end else begin
          quota[g]--;
          vld[g] = (quota[g] > 0);
        end
      end
    end
    if (mode == 2) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!vld[i] && $urandom_range(0, 3) == 0) begin
          vld[i] = 1'b1;
          new_data(i);
        end
      end
    end
    #1;
  endtask

  task automatic single(int id, int a, int b, int expd);
    int n;
    vld = '0;
    d0[id] = a; d1[id] = b; quota[id] = 1; vld[id] = 1'b1;
    saw_rsp = 1'b0; n = 0;
    while (!saw_rsp && n < 20) begin cycle(); n++; end
    chk("single_lat", n, LAT + 1);
    chk("single_dout", last_dout, expd);
    chk("single_id", last_id, id);
    repeat (2) cycle();
  endtask

  initial begin
    int n, r0, a0;
    mode = 0; acc_cnt = 0; rsp_cnt = 0; saw_rsp = 1'b0;
    last_dout = 0; last_id = 0;
    clear_model();
    for (int i = 0; i < NUM_REQ; i++) begin new_data(i); quota[i] = 1; end
    vld = '1;
    ap_rst = 1'b1;
    bus.rsp_ready = 1'b1;
    drive();
    @(posedge ap_clk); #1;

    // Reset held with all requesters valid
    repeat (3) cycle();
    chk("rst_dout", bus.rsp_dout, 0);
    chk("rst_id", bus.rsp_id, 0);
    ap_rst = 1'b0;

    // Fairness: two ops per requester, back-to-back
    for (int i = 0; i < NUM_REQ; i++) quota[i] = 2;
    acc_log = {}; n = 0;
    while (acc_log.size() < 8 && n < 30) begin cycle(); n++; end
    chk("b2b_cycles", n, 8);
    for (int k = 0; k < 8; k++) begin
      if (k < acc_log.size()) chk("rr_order", acc_log[k], k % NUM_REQ);
      else chk("rr_order", 32'hFFFF_FFFF, k % NUM_REQ);
    end
    repeat (LAT + 2) cycle();

    // Single ops and wrap-around products
    single(1, 100, -3, 32'h1ED4);
    single(2, -4096, -128, 0);
    single(3, 4095, 127, 32'h0F81);

    // Backpressure: fill the pipe, stall 5 cycles, release and drain
    for (int i = 0; i < NUM_REQ; i++) begin quota[i] = 3; new_data(i); end
    vld = '1;
    r0 = rsp_cnt;
    repeat (LAT) cycle();
    bus.rsp_ready = 1'b0;
    repeat (5) cycle();
    bus.rsp_ready = 1'b1;
    n = 0;
    while ((vld != '0 || bus.busy !== 1'b0) && n < 40) begin cycle(); n++; end
    chk("bp_drained", (vld == '0 && bus.busy === 1'b0), 1);
    chk("bp_count", rsp_cnt - r0, 12);

    // Reset with two ops in flight
    vld = '0;
    quota[1] = 1; quota[2] = 1; vld[1] = 1'b1; vld[2] = 1'b1;
    repeat (2) cycle();
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    chk("midrst_vld", bus.rsp_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    repeat (LAT + 1) cycle();
    for (int i = 0; i < NUM_REQ; i++) begin quota[i] = 1; new_data(i); end
    vld = '1;
    acc_log = {};
    cycle();
    if (acc_log.size() > 0) chk("rr_restart", acc_log[0], 0);
    else chk("rr_restart", 32'hFFFF_FFFF, 0);
    n = 0;
    while ((vld != '0 || bus.busy !== 1'b0) && n < 40) begin cycle(); n++; end

    // Random traffic with random backpressure
    r0 = rsp_cnt; a0 = acc_cnt;
    mode = 2;
    repeat (400) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    mode = 0;
    for (int i = 0; i < NUM_REQ; i++) quota[i] = 1;
    bus.rsp_ready = 1'b1;
    n = 0;
    while ((vld != '0 || bus.busy !== 1'b0) && n < 100) begin cycle(); n++; end
    chk("rand_drained", (vld == '0 && bus.busy === 1'b0), 1);
    chk("rand_count", rsp_cnt - r0, acc_cnt - a0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
